ex_muldiv_seq: RTL and testbench
================================

Name: ex_muldiv_seq

Overview:
- Iterative multiply/divide sequencer for the RV32M extension, placed beside the EX-stage ALU.
- When a M-extension instruction is in EX, it takes the already-forwarded operands and runs a shift-add multiply or a restoring divide, one bit per cycle.
- It holds the pipeline with `stall` until the result is ready.
- It presents the result for exactly one cycle, to be muxed onto the EX result path.

Parameters:
- WORD_SIZE, 32, operand and result width in bits.
- CNT_W, $clog2(WORD_SIZE)+1, width of the iteration counter.

Ports:
- clk  input  1  pipeline clock.
- rst  input  1  synchronous, active-high reset.
- valid  input  1  M-extension instruction currently in EX.
- op  input  3  RV32M funct3: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
- rs1  input  WORD_SIZE  forwarded operand A (dividend / multiplicand).
- rs2  input  WORD_SIZE  forwarded operand B (divisor / multiplier).
- flush  input  1  branch/jump squash of the EX instruction.
- stall  output  1  hold PC, IF/ID and ID/EX registers.
- result  output  WORD_SIZE  final value; valid only while result_valid is high.
- result_valid  output  1  single-cycle pulse; EX selects result over the ALU.

Behaviour:
- Clock and reset: one clock, clk. rst is synchronous and active-high, sampled on the rising edge.
- On rst: state=IDLE, counter=0, working registers=0, result=0, result_valid=0. rst overrides every other input, including mid-operation; the partial result is discarded.
- States: IDLE, MUL, DIV, DONE.
- IDLE:
  - If valid && !flush, latch op and operands and go to MUL or DIV; counter = WORD_SIZE.
  - Divide by zero or signed overflow goes straight to DONE instead.
  - stall = valid && !flush, combinational in the accept cycle.
- Operand latch:
  - Signed operands are converted to magnitudes.
  - MULH: both operands signed. MULHSU: rs1 signed, rs2 unsigned. DIV/REM: both signed. All others unsigned.
  - Latch sign_res and sign_rem for the final correction.
- MUL:
  - 2*WORD_SIZE-bit accumulator; one multiplier bit per cycle, LSB first; add the shifted multiplicand when the bit is 1.
  - counter decrements every cycle; at counter==1 go to DONE.
- DIV:
  - Restoring division, one quotient bit per cycle, MSB first.
  - partial remainder is WORD_SIZE+1 bits wide so the trial subtract can be checked for a borrow.
  - At counter==1 go to DONE.
- DONE:
  - result_valid=1 and stall=0, so the pipeline advances on this edge. Next state is IDLE.
  - Result selection:
    - MUL: low word of the product (sign-corrected).
    - MULH/MULHSU/MULHU: high word of the sign-corrected product.
    - DIV/DIVU: quotient, negated if sign_res.
    - REM/REMU: remainder, negated if sign_rem. sign_rem = sign of the dividend.
- Latency:
  - Accept edge at T; result_valid high during cycle T+WORD_SIZE+1.
  - stall is high for cycles T through T+WORD_SIZE inclusive (WORD_SIZE+1 stall cycles).
  - Special cases: result_valid during cycle T+1; stall high only in cycle T.
- Special cases, decided in IDLE with no iteration:
  - Divide by zero: DIV/DIVU give all-ones; REM/REMU give rs1.
  - Signed overflow, DIV with rs1=0x80000000 and rs2=0xFFFFFFFF: quotient 0x80000000, REM gives 0.
- stall in MUL/DIV states is 1 regardless of valid. The EX register is frozen, so valid stays high.
- flush in MUL/DIV/DONE: next state IDLE, result_valid forced 0, stall deasserted in the same cycle. The instruction is discarded.
- flush and valid together in IDLE: not accepted, stall=0.
- Back-to-back M ops: after DONE the FSM returns to IDLE. The next op is accepted the cycle after DONE; there is no bubble beyond that.
- result holds its last value when result_valid=0; consumers must ignore it then.
- No operand re-sampling after accept: changes on rs1/rs2 during MUL/DIV are ignored.

Test Plan:
- MUL rs1=7, rs2=0xFFFFFFFD (-3) → stall high 33 cycles, then result=0xFFFFFFEB with a single-cycle result_valid.
- MULHU 0xFFFFFFFF×0xFFFFFFFF → 0xFFFFFFFE. MULH same operands → 0x00000000. MULHSU rs1=-1, rs2=2 → 0xFFFFFFFF.
- DIV rs1=-7, rs2=2 → 0xFFFFFFFD. REM same operands → 0xFFFFFFFF. DIVU 100/7 → 14. REMU 100/7 → 2.
- DIVU 5/0 → 0xFFFFFFFF, REM 5/0 → 5, and DIV 0x80000000/0xFFFFFFFF → 0x80000000. Each has result_valid in the cycle after accept and stall for 1 cycle only.
- Flush at iteration 10 of a DIV → stall drops the same cycle, no result_valid pulse. A following MUL 3×4 → 12 with full latency.
- rst asserted mid-MUL → next cycle state IDLE, stall=0, result=0, result_valid=0. Two back-to-back MULs give two separate result_valid pulses 34 cycles apart.

Source files
------------

// File: rtl/ex_muldiv_seq.sv
// rtl/ex_muldiv_seq.sv - iterative RV32M multiply/divide sequencer beside the EX-stage ALU
module ex_muldiv_seq #(
    parameter int WORD_SIZE = 32,
    parameter int CNT_W     = $clog2(WORD_SIZE) + 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 valid,
    input  logic [2:0]           op,
    input  logic [WORD_SIZE-1:0] rs1,
    input  logic [WORD_SIZE-1:0] rs2,
    input  logic                 flush,
    output logic                 stall,
    output logic [WORD_SIZE-1:0] result,
    output logic                 result_valid
);
    localparam int W2 = 2 * WORD_SIZE;

    typedef enum logic [1:0] {IDLE, MUL, DIV, DONE} state_t;

    state_t               state, state_nxt;
    logic                 accept;
    logic [CNT_W-1:0]     counter;
    logic [1:0]           op_q;
    logic                 sign_res, sign_rem;
    logic [WORD_SIZE-1:0] a_reg;   // multiplier, or dividend shifting into quotient
    logic [WORD_SIZE-1:0] rem;
    logic [W2-1:0]        b_reg;   // shifting multiplicand, or divisor in the low word
    logic [W2-1:0]        acc;

    logic                 signed_a, signed_b, neg_a, neg_b;
    logic [WORD_SIZE-1:0] mag_a, mag_b;
    logic                 div_zero, div_ovf;
    logic [WORD_SIZE-1:0] special_res;

    assign signed_a = (op == 3'b001) || (op == 3'b010) || (op == 3'b100) || (op == 3'b110);
    assign signed_b = (op == 3'b001) || (op == 3'b100) || (op == 3'b110);
    assign neg_a    = signed_a && rs1[WORD_SIZE-1];
    assign neg_b    = signed_b && rs2[WORD_SIZE-1];
    assign mag_a    = neg_a ? -rs1 : rs1;
    assign mag_b    = neg_b ? -rs2 : rs2;
    assign div_zero = op[2] && (rs2 == '0);
    assign div_ovf  = op[2] && !op[0] && (rs1 == {1'b1, {(WORD_SIZE-1){1'b0}}}) && (rs2 == '1);
    // On signed overflow the quotient equals the dividend, so rs1 serves both cases.
    assign special_res = div_zero ? (op[1] ? rs1 : '1) : (op[1] ? '0 : rs1);

    logic [W2-1:0]        acc_nxt, prod;
    logic [WORD_SIZE:0]   trial, diff;
    logic                 borrow;
    logic [WORD_SIZE-1:0] rem_nxt, q_nxt, quot, rem_fix;

    assign acc_nxt = a_reg[0] ? acc + b_reg : acc;
    assign prod    = sign_res ? -acc_nxt : acc_nxt;
    assign trial   = {rem, a_reg[WORD_SIZE-1]};
    assign diff    = trial - {1'b0, b_reg[WORD_SIZE-1:0]};
    assign borrow  = diff[WORD_SIZE];
    assign rem_nxt = borrow ? trial[WORD_SIZE-1:0] : diff[WORD_SIZE-1:0];
    assign q_nxt   = {a_reg[WORD_SIZE-2:0], !borrow};
    assign quot    = sign_res ? -q_nxt : q_nxt;
    assign rem_fix = sign_rem ? -rem_nxt : rem_nxt;

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt    = state;
        stall        = 1'b0;
        result_valid = 1'b0;
        accept       = 1'b0;
        unique case (state)
            IDLE: begin
                if (valid && !flush) begin
                    stall  = 1'b1;
                    accept = 1'b1;
                    if (div_zero || div_ovf) state_nxt = DONE;
                    else if (op[2])          state_nxt = DIV;
                    else                     state_nxt = MUL;
                end
            end
            MUL, DIV: begin
                stall = !flush;
                if (flush)                          state_nxt = IDLE;
                else if (counter == CNT_W'(1))      state_nxt = DONE;
            end
            DONE: begin
                result_valid = !flush;
                state_nxt    = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            counter  <= '0;
            op_q     <= '0;
            sign_res <= 1'b0;
            sign_rem <= 1'b0;
            a_reg    <= '0;
            rem      <= '0;
            b_reg    <= '0;
            acc      <= '0;
            result   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        op_q     <= op[1:0];
                        counter  <= CNT_W'(WORD_SIZE);
                        a_reg    <= op[2] ? mag_a : mag_b;
                        b_reg    <= {{WORD_SIZE{1'b0}}, (op[2] ? mag_b : mag_a)};
                        acc      <= '0;
                        rem      <= '0;
                        sign_res <= neg_a ^ neg_b;
                        sign_rem <= neg_a;
                        if (div_zero || div_ovf) result <= special_res;
                    end
                end
                MUL: begin
                    counter <= counter - CNT_W'(1);
                    acc     <= acc_nxt;
                    b_reg   <= b_reg << 1;
                    a_reg   <= a_reg >> 1;
                    if (counter == CNT_W'(1))
                        result <= (op_q == 2'b00) ? prod[WORD_SIZE-1:0] : prod[W2-1:WORD_SIZE];
                end
                DIV: begin
                    counter <= counter - CNT_W'(1);
                    rem     <= rem_nxt;
                    a_reg   <= q_nxt;
                    if (counter == CNT_W'(1))
                        result <= op_q[1] ? rem_fix : quot;
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_ex_muldiv_seq.sv
// tb/tb_ex_muldiv_seq.sv - directed scoreboard bench for ex_muldiv_seq
module tb_ex_muldiv_seq;
    logic        clk = 1'b0;
    logic        rst, valid, flush;
    logic [2:0]  op;
    logic [31:0] rs1, rs2;
    logic        stall, result_valid;
    logic [31:0] result;

    int          n_checks = 0;
    int          n_err    = 0;
    int          cycle_cnt = 0;
    logic [31:0] sb_q[$];

    ex_muldiv_seq #(.WORD_SIZE(32)) dut (
        .clk(clk), .rst(rst), .valid(valid), .op(op), .rs1(rs1), .rs2(rs2),
        .flush(flush), .stall(stall), .result(result), .result_valid(result_valid)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cycle_cnt <= cycle_cnt + 1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic do_op(input string tag, input logic [2:0] o, input logic [31:0] a,
                         input logic [31:0] b, input logic [31:0] exp_res,
                         input int exp_lat, input int exp_stall, input bit keep_valid,
                         output int rv_time);
        int cyc, stalls, lat;
        bit got;
        logic [31:0] exp_v;
        @(negedge clk);
        valid = 1'b1; op = o; rs1 = a; rs2 = b;
        sb_q.push_back(exp_res);
        cyc = 0; stalls = 0; got = 0; lat = -1; rv_time = 0;
        while (!got && cyc < 80) begin
            #1;
            if (stall) stalls++;
            if (result_valid) begin
                got = 1; lat = cyc; rv_time = cycle_cnt;
                exp_v = (sb_q.size() > 0) ? sb_q.pop_front() : 32'hDEAD_BEEF;
                chk({tag, " result"}, result, exp_v);
            end else begin
                @(negedge clk);
                cyc++;
                rs1 = $urandom; rs2 = $urandom;
            end
        end
        chk({tag, " got_pulse"}, 32'(got), 32'd1);
        chk({tag, " latency"}, 32'(lat), 32'(exp_lat));
        chk({tag, " stall_cycles"}, 32'(stalls), 32'(exp_stall));
        if (!keep_valid) begin
            valid = 1'b0;
            @(negedge clk); #1;
            chk({tag, " single_pulse"}, 32'(result_valid), 32'd0);
        end
    endtask

    initial begin
        int t1, t2, pulses;
        rst = 1'b1; valid = 1'b0; flush = 1'b0; op = 3'b000; rs1 = '0; rs2 = '0;
        repeat (3) @(negedge clk);
        #1;
        chk("reset stall", 32'(stall), 32'd0);
        chk("reset result_valid", 32'(result_valid), 32'd0);
        chk("reset result", result, 32'd0);
        @(negedge clk); rst = 1'b0;

        do_op("MUL 7*-3",       3'b000, 32'd7,          32'hFFFF_FFFD, 32'hFFFF_FFEB, 33, 33, 0, t1);
        do_op("MULHU -1*-1",    3'b011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 33, 33, 0, t1);
        do_op("MULH -1*-1",     3'b001, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000, 33, 33, 0, t1);
        do_op("MULHSU -1*2",    3'b010, 32'hFFFF_FFFF, 32'd2,          32'hFFFF_FFFF, 33, 33, 0, t1);
        do_op("DIV -7/2",       3'b100, 32'hFFFF_FFF9, 32'd2,          32'hFFFF_FFFD, 33, 33, 0, t1);
        do_op("REM -7/2",       3'b110, 32'hFFFF_FFF9, 32'd2,          32'hFFFF_FFFF, 33, 33, 0, t1);
        do_op("DIVU 100/7",     3'b101, 32'd100,        32'd7,          32'd14,        33, 33, 0, t1);
        do_op("REMU 100/7",     3'b111, 32'd100,        32'd7,          32'd2,         33, 33, 0, t1);
        do_op("DIVU 5/0",       3'b101, 32'd5,          32'd0,          32'hFFFF_FFFF, 1, 1, 0, t1);
        do_op("REM 5/0",        3'b110, 32'd5,          32'd0,          32'd5,         1, 1, 0, t1);
        do_op("DIV ovf",        3'b100, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1, 1, 0, t1);
        do_op("REM ovf",        3'b110, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 1, 1, 0, t1);

        // flush at iteration 10 of a DIV
        @(negedge clk);
        valid = 1'b1; op = 3'b100; rs1 = 32'd1000; rs2 = 32'd3;
        repeat (10) @(negedge clk);
        flush = 1'b1; #1;
        chk("flush stall", 32'(stall), 32'd0);
        chk("flush result_valid", 32'(result_valid), 32'd0);
        @(negedge clk); #1;
        chk("flush+valid idle stall", 32'(stall), 32'd0);
        @(negedge clk);
        valid = 1'b0; flush = 1'b0;
        pulses = 0;
        repeat (40) begin @(negedge clk); #1; if (result_valid) pulses++; end
        chk("flush no pulse", 32'(pulses), 32'd0);
        do_op("MUL 3*4",        3'b000, 32'd3,          32'd4,          32'd12,        33, 33, 0, t1);

        // reset mid-MUL
        @(negedge clk);
        valid = 1'b1; op = 3'b000; rs1 = 32'd9; rs2 = 32'd9;
        repeat (10) @(negedge clk);
        rst = 1'b1; valid = 1'b0;
        @(posedge clk); #1;
        chk("rst mid stall", 32'(stall), 32'd0);
        chk("rst mid result", result, 32'd0);
        chk("rst mid result_valid", 32'(result_valid), 32'd0);
        @(negedge clk); rst = 1'b0;
        pulses = 0;
        repeat (40) begin @(negedge clk); #1; if (result_valid) pulses++; end
        chk("rst no pulse", 32'(pulses), 32'd0);

        // back-to-back
        do_op("B2B MUL 5*6",    3'b000, 32'd5,          32'd6,          32'd30,        33, 33, 1, t1);
        do_op("B2B MULHU",      3'b011, 32'h8000_0000, 32'd4,          32'd2,         33, 33, 0, t2);
        chk("b2b spacing", 32'(t2 - t1), 32'd34);
        chk("scoreboard empty", 32'(sb_q.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end
endmodule
